mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
Sequences every load/store from the MEM stage into the data cache over a variable-latency req/ack handshake. Checks alignment, generates byte enables and lane-replicated store data, and zero/sign-extends load data into a one-cycle response. Raises busy to the hazard unit while an access is outstanding. Sits between the MEM-stage pipeline register and the data cache.

Parameters:
ADDR_W, 32, byte address width.
TIMEOUT_CYCLES, 255, maximum cycles waiting for cache_ack; used only with the optional feature.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  pipeline presents an access.
req_ready  out  1  controller can accept (high only in IDLE).
req_we  in  1  1 = store, 0 = load.
req_load_type  in  3  `LB/`LH/`LW/`LBU/`LHU/`NOREGWRITE (Parameters.v encodings).
req_store_type  in  2  ST_B=2'b01, ST_H=2'b10, ST_W=2'b11.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data, right-aligned.
cache_req  out  1  access request to cache.
cache_addr  out  ADDR_W  word address, low 2 bits forced to 0.
cache_be  out  4  byte enables (0 for loads).
cache_wdata  out  32  lane-replicated store data.
cache_ack  in  1  cache completes the access in this cycle.
cache_rdata  in  32  read word, valid with cache_ack.
resp_valid  out  1  one-cycle completion pulse.
resp_data  out  32  extended load data (0 for stores and errors).
resp_err  out  1  misaligned access (or timeout).
busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE. cache_req, cache_be, cache_addr, cache_wdata, resp_valid, resp_data and resp_err are 0. req_ready=1 once reset is released.
- States: IDLE, WAIT, RESP. All outputs are registered except req_ready and busy, which decode the state.
- IDLE, req_valid=1: latch type, addr[1:0] and wdata. Then:
  - misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> RESP with resp_err=1; no cache access.
  - load with `NOREGWRITE -> RESP, data 0, no cache access.
  - otherwise -> WAIT, with cache_req=1 from the next cycle.
- WAIT: cache_req, cache_addr, cache_be and cache_wdata stay stable until cache_ack. On cache_ack: deassert cache_req, register resp_data and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready is 0 in RESP; back-to-back requests cost one idle cycle.
- Minimum latency: accept at cycle T, cache_req at T+1, ack at T+1, resp_valid at T+2.
- cache_ack outside WAIT is ignored.
- Byte enables: ST_B = 4'b0001<<addr[1:0], data {4{wdata[7:0]}]. ST_H = 4'b0011<<addr[1:0], data {2{wdata[15:0]}}. ST_W = 4'b1111, data wdata.
- Load extension, by latched addr[1:0]:
  - LB/LBU select byte lane addr[1:0], sign/zero extend.
  - LH/LHU select half [15:0] or [31:16], sign/zero extend.
  - LW passes the word through.
  - Unknown load type yields 0.
- Reset mid-operation drops cache_req asynchronously. The cache must discard an abandoned request.

Optional Feature:
MEM_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle. Reaching TIMEOUT_CYCLES without ack deasserts cache_req and goes to RESP with resp_err=1, resp_data=0. An ack arriving in the same cycle as the timeout takes priority.
- Undefined: no counter; WAIT holds indefinitely.

Decomposition:
- Shared package/header: ST_B/ST_H/ST_W encodings, state encodings. Load types come from the existing Parameters.v macros.
- One sub-module: the existing DataExtend, instantiated on cache_rdata with latched addr[1:0] and load type. It supplies the extension logic; its output is registered into resp_data on ack.

Test Plan:
- LB addr 0x1003, ack same cycle as req, rdata 0x80FF_0000 -> cache_addr 0x1000, resp at T+2, resp_data 0xFFFF_FF80.
- LHU addr 0x2002, ack after 5 WAIT cycles, rdata 0xBEEF_1234 -> resp_data 0x0000_BEEF, busy high for 7 cycles.
- SB addr 0x3001, wdata 0x0000_00A5 -> cache_be 4'b0010, cache_wdata 0xA5A5_A5A5, resp_data 0.
- LW addr 0x4002 -> resp_err=1 at T+1, cache_req never asserted.
- rst_n low while in WAIT -> cache_req 0 immediately, state IDLE; next request completes normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> resp_err=1 after 4 WAIT cycles, cache_req drops the same edge.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: store-type, load-type and FSM state encodings shared by the controller.
package mem_access_ctrl_pkg;
  localparam logic [1:0] ST_B = 2'b01;
  localparam logic [1:0] ST_H = 2'b10;
  localparam logic [1:0] ST_W = 2'b11;
  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_B = 3'd1;
  localparam logic [2:0] LD_H = 3'd2;
  localparam logic [2:0] LD_W = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;
  localparam logic [2:0] LD_HU = 3'd5;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
endpackage

// File: rtl/mem_access_ctrl_data_extend.sv
// mem_access_ctrl_data_extend: selects the addressed byte/half of a read word and sign/zero extends it.
module mem_access_ctrl_data_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  ld_type_i,
  output logic [31:0] ext_o
);
  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    sh = data_i >> {off_i, 3'b000};
    b = sh[7:0];
    h = off_i[1] ? data_i[31:16] : data_i[15:0];
    ext_o = ld_type_i == LD_B  ? {{24{b[7]}}, b} :
            ld_type_i == LD_BU ? {24'd0, b} :
            ld_type_i == LD_H  ? {{16{h[15]}}, h} :
            ld_type_i == LD_HU ? {16'd0, h} :
            ld_type_i == LD_W  ? data_i : 32'd0;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer over a req/ack data-cache handshake.
// Define MEM_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYCLES with resp_err.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_load_type,
  input  logic [1:0]        req_store_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              cache_req,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [3:0]        cache_be,
  output logic [31:0]       cache_wdata,
  input  logic              cache_ack,
  input  logic [31:0]       cache_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              busy
);
  state_e state_q;
  logic cache_req_q, resp_valid_q, resp_err_q, we_q;
  logic [ADDR_W-1:0] cache_addr_q;
  logic [3:0] cache_be_q, be_d;
  logic [31:0] cache_wdata_q, resp_data_q, wdata_d, ext;
  logic [2:0] ld_type_q;
  logic [1:0] off_q, off;
  logic mis_d;
`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
`endif
  mem_access_ctrl_data_extend u_ext (
    .data_i    (cache_rdata),
    .off_i     (off_q),
    .ld_type_i (ld_type_q),
    .ext_o     (ext)
  );
  always_comb begin
    off = req_addr[1:0];
    be_d = !req_we ? 4'b0000 :
           req_store_type == ST_B ? 4'b0001 << off :
           req_store_type == ST_H ? 4'b0011 << off :
           req_store_type == ST_W ? 4'b1111 : 4'b0000;
    wdata_d = req_store_type == ST_B ? {4{req_wdata[7:0]}} :
              req_store_type == ST_H ? {2{req_wdata[15:0]}} : req_wdata;
    mis_d = req_we ? (req_store_type == ST_H && off[0]) || (req_store_type == ST_W && off != 2'b00)
                   : ((req_load_type == LD_H || req_load_type == LD_HU) && off[0]) ||
                     (req_load_type == LD_W && off != 2'b00);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cache_req_q <= 1'b0;
      cache_addr_q <= '0;
      cache_be_q <= 4'b0;
      cache_wdata_q <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_data_q <= 32'd0;
      resp_err_q <= 1'b0;
      we_q <= 1'b0;
      ld_type_q <= LD_NONE;
      off_q <= 2'b00;
`ifdef MEM_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          we_q <= req_we;
          ld_type_q <= req_load_type;
          off_q <= off;
          if (mis_d || (!req_we && req_load_type == LD_NONE)) begin
            state_q <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q <= mis_d;
            resp_data_q <= 32'd0;
          end else begin
            state_q <= S_WAIT;
            cache_req_q <= 1'b1;
            cache_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
            cache_be_q <= be_d;
            cache_wdata_q <= wdata_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q <= '0;
`endif
          end
        end
        S_WAIT: if (cache_ack) begin
          state_q <= S_RESP;
          cache_req_q <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_data_q <= we_q ? 32'd0 : ext;
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_q <= S_RESP;
          cache_req_q <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_err_q <= 1'b1;
          resp_data_q <= 32'd0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
`endif
        end
        default: begin
          state_q <= S_IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q <= 1'b0;
          resp_data_q <= 32'd0;
        end
      endcase
    end
  end
  assign req_ready = state_q == S_IDLE;
  assign busy = state_q != S_IDLE;
  assign cache_req = cache_req_q;
  assign cache_addr = cache_addr_q;
  assign cache_be = cache_be_q;
  assign cache_wdata = cache_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_data = resp_data_q;
  assign resp_err = resp_err_q;
endmodule
